// File: rtl/apb_pkg.sv
// Shared types and constants for the APB write master slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package apb_pkg;

   localparam int APB_DATA_W = 8;
   localparam int APB_SEL_W  = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Register selects understood by the payload/size slave; 3 is unmapped.
   localparam logic [APB_SEL_W-1:0] SEL_PAYLOAD0 = 2'd0;
   localparam logic [APB_SEL_W-1:0] SEL_PAYLOAD1 = 2'd1;
   localparam logic [APB_SEL_W-1:0] SEL_SIZE     = 2'd2;

   typedef struct packed {
      logic [APB_SEL_W-1:0]  sel;
      logic [APB_DATA_W-1:0] data;
   } apb_wr_cmd_t;

endpackage

// File: rtl/apb_write_master_if.sv
// Command request and APB write bus bundle between requester and register slave.
// Latency: none (wires only).
// Backpressure: req_ready gates the command side; pready stretches APB ACCESS.
interface apb_write_master_if
   import apb_pkg::*;
#(
   parameter int DATA_W = APB_DATA_W,
   parameter int SEL_W  = APB_SEL_W
);
   logic              req_valid;
   logic              req_ready;
   logic [SEL_W-1:0]  req_sel;
   logic [DATA_W-1:0] req_data;
   logic              psel_x;
   logic              penable;
   logic              pwrite;
   logic [SEL_W-1:0]  write_select;
   logic [DATA_W-1:0] pwdata;
   logic              pready;
   logic              done;
   logic              busy;
   logic              err_clr;
   logic              timeout_err;

   modport master (
      input  req_valid, req_sel, req_data, pready, err_clr,
      output req_ready, psel_x, penable, pwrite, write_select, pwdata,
             done, busy, timeout_err
   );

   modport slave (
      output req_valid, req_sel, req_data, pready, err_clr,
      input  req_ready, psel_x, penable, pwrite, write_select, pwdata,
             done, busy, timeout_err
   );
endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; DEPTH must be a power of two.
// Latency: pushed entry visible at the head one cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module apb_cmd_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             pclk,
   input  logic             preset_n,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push_vld && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem_q[rd_ptr_q];

   // Pointer, occupancy and storage updates; pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers; reset discards all contents.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/apb_write_master.sv
// Buffers write commands and issues each as a two-phase APB write (SETUP, ACCESS); optional ACCESS abort under APB_MASTER_TIMEOUT_EN.
// Latency: push at edge k -> SETUP after k+1, ACCESS after k+2, done high after k+3 with no wait states; 2 cycles/write back-to-back.
// Backpressure: req_ready = !fifo_full; pready low holds ACCESS (bounded by TIMEOUT_CYCLES when APB_MASTER_TIMEOUT_EN is defined).
module apb_write_master #(
   parameter int DATA_W         = 8,
   parameter int SEL_W          = 2,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                pclk,
   input logic                preset_n,
   apb_write_master_if.master bus
);
   import apb_pkg::*;

   localparam int CMD_W = SEL_W + DATA_W;

   apb_state_e        state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              done_q, done_d;
   logic [SEL_W-1:0]  wsel_q, wsel_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;

   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CMD_W-1:0]  fifo_head;
   logic [SEL_W-1:0]  head_sel;
   logic [DATA_W-1:0] head_data;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             timeout_err_q, timeout_err_d;
`else
   // Timeout configuration and error clear have no function in this build.
   logic unused_cfg;
   assign unused_cfg = bus.err_clr ^ (TIMEOUT_CYCLES == 0);
`endif

   apb_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .pclk     (pclk),
      .preset_n (preset_n),
      .push_vld (bus.req_valid),
      .push_dat ({bus.req_sel, bus.req_data}),
      .pop      (fifo_pop),
      .pop_dat  (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign head_sel  = fifo_head[CMD_W-1:DATA_W];
   assign head_data = fifo_head[DATA_W-1:0];

   // Next-state and bus outputs; address/data registers only change on a pop.
   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      wsel_d    = wsel_q;
      pwdata_d  = pwdata_q;
      done_d    = 1'b0;
      fifo_pop  = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
      timeout_err_d = timeout_err_q & ~bus.err_clr;
`endif
      case (state_q)
         IDLE: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               wsel_d   = head_sel;
               pwdata_d = head_data;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         ACCESS: begin
            if (bus.pready) begin
               done_d = 1'b1;
               if (!fifo_empty) begin
                  // Chain straight into the next SETUP; psel stays high.
                  fifo_pop  = 1'b1;
                  wsel_d    = head_sel;
                  pwdata_d  = head_data;
                  penable_d = 1'b0;
                  state_d   = SETUP;
               end else begin
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
                  state_d   = IDLE;
               end
            end else begin
`ifdef APB_MASTER_TIMEOUT_EN
               tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
               if (tmo_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                  // Abort: release the bus silently, flag the error (set beats clear).
                  psel_d        = 1'b0;
                  penable_d     = 1'b0;
                  timeout_err_d = 1'b1;
                  state_d       = IDLE;
               end
`endif
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   // State and registered bus outputs; reset drops the bus immediately.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q   <= IDLE;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         done_q    <= 1'b0;
         wsel_q    <= '0;
         pwdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         done_q    <= done_d;
         wsel_q    <= wsel_d;
         pwdata_q  <= pwdata_d;
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   // ACCESS wait counter and sticky abort flag.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         tmo_cnt_q     <= tmo_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.timeout_err = timeout_err_q;
`else
   assign bus.timeout_err = 1'b0;
`endif

   assign bus.req_ready    = !fifo_full;
   assign bus.psel_x       = psel_q;
   assign bus.penable      = penable_q;
   assign bus.pwrite       = psel_q;
   assign bus.write_select = wsel_q;
   assign bus.pwdata       = pwdata_q;
   assign bus.done         = done_q;
   assign bus.busy         = (state_q != IDLE) || !fifo_empty;

endmodule
